// File: rtl/multiplicador_seq.sv
// Iterative shift-add multiplier: TAM x TAM -> 2*TAM product, one multiplier bit per cycle.
// Optional signed mode enabled by defining MULT_SIGNED_EN (adds the sgn port).
module multiplicador_seq #(
  parameter int unsigned TAM = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TAM-1:0]     A,
  input  logic [TAM-1:0]     B,
`ifdef MULT_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*TAM-1:0]   S
);

  localparam int unsigned W2 = 2 * TAM;
  localparam int unsigned CW = $clog2(TAM) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [TAM-1:0]  a_reg;
  logic [TAM-1:0]  b_reg;
  logic [W2-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            neg_reg;

  logic [TAM-1:0]  a_load;
  logic [TAM-1:0]  b_load;
  logic            neg_load;
  logic [W2-1:0]   addend;
  logic [W2-1:0]   acc_next;
  logic [W2-1:0]   result;

  // Operands are stored as magnitudes; the sign is reapplied when the product lands in S.
  always_comb begin
    a_load   = A;
    b_load   = B;
    neg_load = 1'b0;
`ifdef MULT_SIGNED_EN
    if (sgn) begin
      if (A[TAM-1]) a_load = ~A + TAM'(1);
      if (B[TAM-1]) b_load = ~B + TAM'(1);
      neg_load = A[TAM-1] ^ B[TAM-1];
    end
`endif
  end

  always_comb begin
    addend   = b_reg[0] ? (W2'(a_reg) << cnt) : '0;
    acc_next = acc + addend;
    result   = neg_reg ? (~acc_next + W2'(1)) : acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      neg_reg <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state   <= CALC;
            busy    <= 1'b1;
            a_reg   <= a_load;
            b_reg   <= b_load;
            neg_reg <= neg_load;
            acc     <= '0;
            cnt     <= '0;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc   <= acc_next;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + CW'(1);
          // Last partial product: publish the whole result in one edge.
          if (cnt == CW'(TAM - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            S     <= result;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
